// File: rtl/acc_sched_pkg.sv
// Shared types and helpers for the accumulate sweep scheduler.
package acc_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   // Channel index width: at least one bit even for a single channel
   function automatic int unsigned ch_w(input int unsigned n);
      if (n < 2) begin
         return 1;
      end else begin
         return int'($clog2(n));
      end
   endfunction

endpackage

// File: rtl/acc_regfile.sv
// Per-channel increment / accumulator storage.
// One read-modify port serves the sweep; one write port serves configuration.
module acc_regfile
   import acc_sched_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned ACC_WIDTH = 8,
   parameter int unsigned ADD_WIDTH = 8,
   parameter int unsigned CH_W      = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   // read-modify port
   input  logic [CH_W-1:0]      rmw_ch,
   output logic [ADD_WIDTH-1:0] rmw_inc,
   output logic [ACC_WIDTH-1:0] rmw_acc,
   input  logic                 rmw_we,
   input  logic [ACC_WIDTH-1:0] rmw_val,
   // config write port
   input  logic                 wr_en,
   input  logic [CH_W-1:0]      wr_ch,
   input  logic [ADD_WIDTH-1:0] wr_inc,
   input  logic                 wr_clr
);

   logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
   logic [ADD_WIDTH-1:0] inc_q [NUM_CH];

   // Combinational read of the channel currently being swept
   always_comb begin
      rmw_inc = '0;
      rmw_acc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rmw_ch == CH_W'(i)) begin
            rmw_inc = inc_q[i];
            rmw_acc = acc_q[i];
         end
      end
   end

   // Storage update; indices at or beyond NUM_CH match no entry, so such writes vanish.
   // A config clear beats a same-cycle accumulate on the same channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= '0;
            inc_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
               inc_q[i] <= wr_inc;
            end
            if (wr_en && wr_clr && (wr_ch == CH_W'(i))) begin
               acc_q[i] <= '0;
            end else if (rmw_we && (rmw_ch == CH_W'(i))) begin
               acc_q[i] <= rmw_val;
            end
         end
      end
   end

endmodule

// File: rtl/acc_sweep_scheduler.sv
// Time-multiplexes one accumulate adder over NUM_CH channels.
// A tick launches a sweep of channels 0..NUM_CH-1; each result goes out on a valid/ready stream.
module acc_sweep_scheduler
   import acc_sched_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned ACC_WIDTH = 8,
   parameter int unsigned ADD_WIDTH = 8,
   localparam int unsigned CH_W     = ch_w(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [ADD_WIDTH-1:0] cfg_inc,
   input  logic                 cfg_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH_W-1:0]      out_ch,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 busy,
   output logic                 sweep_done,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   state_e               state_q, state_d;
   logic [CH_W-1:0]      ch_idx_q, ch_idx_d;
   logic                 out_valid_q;
   logic [CH_W-1:0]      out_ch_q;
   logic [ACC_WIDTH-1:0] out_data_q;
   logic                 sweep_done_q;
   logic                 overrun_q;

   logic                 issue;
   logic                 last_ch;
   logic [ADD_WIDTH-1:0] rd_inc;
   logic [ACC_WIDTH-1:0] rd_acc;
   logic [ACC_WIDTH-1:0] sum;

   assign cfg_ready = 1'b1;

   acc_regfile #(
      .NUM_CH    (NUM_CH),
      .ACC_WIDTH (ACC_WIDTH),
      .ADD_WIDTH (ADD_WIDTH),
      .CH_W      (CH_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .rmw_ch  (ch_idx_q),
      .rmw_inc (rd_inc),
      .rmw_acc (rd_acc),
      .rmw_we  (issue),
      .rmw_val (sum),
      .wr_en   (cfg_valid),
      .wr_ch   (cfg_ch),
      .wr_inc  (cfg_inc),
      .wr_clr  (cfg_clr)
   );

   // FSM state and channel counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ch_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         ch_idx_q <= ch_idx_d;
      end
   end

   // Next state: a tick starts a sweep, issuing the last channel ends it
   always_comb begin
      state_d  = state_q;
      ch_idx_d = ch_idx_q;
      unique case (state_q)
         StIdle: begin
            if (tick) begin
               state_d  = StRun;
               ch_idx_d = '0;
            end
         end
         StRun: begin
            if (issue) begin
               if (last_ch) begin
                  state_d  = StIdle;
                  ch_idx_d = '0;
               end else begin
                  ch_idx_d = ch_idx_q + CH_W'(1);
               end
            end
         end
         default: begin
            state_d  = StIdle;
            ch_idx_d = '0;
         end
      endcase
   end

   // Issue decision and shared adder; the increment is zero-extended by the cast
   always_comb begin
      busy    = (state_q == StRun);
      issue   = busy && (!out_valid_q || out_ready);
      last_ch = (ch_idx_q == CH_W'(NUM_CH - 1));
      sum     = rd_acc + ACC_WIDTH'(rd_inc);
   end

   // Output register: load on issue, drop valid once accepted, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         out_data_q   <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         sweep_done_q <= issue && last_ch;
         if (issue) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_idx_q;
            out_data_q  <= sum;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Sticky overrun flag for ticks dropped mid-sweep; the clear takes priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (overrun_clr) begin
         overrun_q <= 1'b0;
      end else if (tick && (state_q == StRun)) begin
         overrun_q <= 1'b1;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign out_data   = out_data_q;
   assign sweep_done = sweep_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_acc_sweep_scheduler.sv
// Bench for acc_sweep_scheduler: directed scenarios plus randomized sweeps,
// checked against a per-channel accumulate model and an expected-beat queue.
module tb_acc_sweep_scheduler;

   localparam int NUM_CH    = 4;
   localparam int ACC_WIDTH = 8;
   localparam int ADD_WIDTH = 8;
   localparam int CH_W      = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 tick;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CH_W-1:0]      cfg_ch;
   logic [ADD_WIDTH-1:0] cfg_inc;
   logic                 cfg_clr;
   logic                 out_valid;
   logic                 out_ready;
   logic [CH_W-1:0]      out_ch;
   logic [ACC_WIDTH-1:0] out_data;
   logic                 busy;
   logic                 sweep_done;
   logic                 overrun;
   logic                 overrun_clr;

   always #5 clk = ~clk;

   acc_sweep_scheduler #(
      .NUM_CH    (NUM_CH),
      .ACC_WIDTH (ACC_WIDTH),
      .ADD_WIDTH (ADD_WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_inc     (cfg_inc),
      .cfg_clr     (cfg_clr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ch      (out_ch),
      .out_data    (out_data),
      .busy        (busy),
      .sweep_done  (sweep_done),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   typedef struct {
      int ch;
      int data;
   } beat_t;

   beat_t exp_q[$];
   int    acc_m [NUM_CH];
   int    inc_m [NUM_CH];
   int    n_cmp  = 0;
   int    n_fail = 0;

   logic                 prev_held = 1'b0;
   logic [CH_W-1:0]      prev_ch   = '0;
   logic [ACC_WIDTH-1:0] prev_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: one sweep adds each channel's increment to its accumulator, mod 256
   task automatic model_sweep();
      for (int c = 0; c < NUM_CH; c++) begin
         acc_m[c] = (acc_m[c] + inc_m[c]) % 256;
         exp_q.push_back('{ch: c, data: acc_m[c]});
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         acc_m[c] = 0;
         inc_m[c] = 0;
      end
      exp_q.delete();
   endtask

   task automatic cfg_write(input int ch, input int inc, input bit clr);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_inc   = ADD_WIDTH'(inc);
      cfg_clr   = clr;
      step();
      cfg_valid = 1'b0;
      cfg_clr   = 1'b0;
      inc_m[ch] = inc;
      if (clr) acc_m[ch] = 0;
   endtask

   task automatic start_sweep();
      tick = 1'b1;
      model_sweep();
      step();
      tick = 1'b0;
   endtask

   // Run until every expected beat has been accepted, with a cycle budget
   task automatic drain(input bit rnd);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         step();
         n++;
      end
      out_ready = 1'b1;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Stream monitor: accepted beats against the queue, holding under stall, sweep_done timing
   always @(negedge clk) begin : mon
      beat_t b;
      logic  exp_done;
      if (rst) begin
         prev_held = 1'b0;
      end else begin
         if (prev_held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ch", 32'(out_ch), 32'(prev_ch));
            chk("hold_data", 32'(out_data), 32'(prev_data));
         end
         exp_done = out_valid && !prev_held && (exp_q.size() != 0) &&
                    (exp_q[0].ch == NUM_CH - 1);
         chk("sweep_done", 32'(sweep_done), 32'(exp_done));
         if (out_valid && out_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL extra_beat: observed ch %0d data %0d expected no beat",
                      out_ch, out_data);
            end
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               chk("beat_ch", 32'(out_ch), 32'(b.ch));
               chk("beat_data", 32'(out_data), 32'(b.data));
            end
         end
         prev_held = out_valid && !out_ready;
         prev_ch   = out_ch;
         prev_data = out_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      tick        = 1'b0;
      cfg_valid   = 1'b0;
      cfg_ch      = '0;
      cfg_inc     = '0;
      cfg_clr     = 1'b0;
      out_ready   = 1'b1;
      overrun_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sweep_done", 32'(sweep_done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("cfg_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b0;
      step();

      // Basic sweep with inc {1,2,3,4}, plus tick-to-first-beat latency
      for (int c = 0; c < NUM_CH; c++) cfg_write(c, c + 1, 1'b0);
      tick = 1'b1;
      model_sweep();
      step();
      tick = 1'b0;
      @(negedge clk);
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_valid_t1", 32'(out_valid), 32'd0);
      step();
      @(negedge clk);
      chk("lat_valid_t2", 32'(out_valid), 32'd1);
      step();
      drain(1'b0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Three sweeps from cleared accumulators
      for (int c = 0; c < NUM_CH; c++) cfg_write(c, c + 1, 1'b1);
      repeat (3) begin
         start_sweep();
         drain(1'b0);
      end

      // Wraparound on channel 0
      cfg_write(0, 200, 1'b1);
      repeat (2) begin
         start_sweep();
         drain(1'b0);
      end

      // Backpressure on ch1 for three cycles
      tick = 1'b1;
      model_sweep();
      step();
      tick = 1'b0;
      step();
      step();
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_ch", 32'(out_ch), 32'd1);
         chk("bp_busy", 32'(busy), 32'd1);
         step();
      end
      out_ready = 1'b1;
      drain(1'b0);

      // Tick during a sweep is dropped and flags overrun
      tick = 1'b1;
      model_sweep();
      step();
      step();
      tick = 1'b0;
      @(negedge clk);
      chk("overrun_set", 32'(overrun), 32'd1);
      drain(1'b0);
      repeat (3) step();
      chk("overrun_sticky", 32'(overrun), 32'd1);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      @(negedge clk);
      chk("overrun_cleared", 32'(overrun), 32'd0);

      // Clear beats a same-cycle overrun set
      tick = 1'b1;
      model_sweep();
      step();
      overrun_clr = 1'b1;
      step();
      tick = 1'b0;
      overrun_clr = 1'b0;
      @(negedge clk);
      chk("overrun_clr_wins", 32'(overrun), 32'd0);
      drain(1'b0);

      // Config write with clear on ch2 in the cycle ch2 issues
      for (int c = 0; c < NUM_CH; c++) cfg_write(c, c + 1, 1'b1);
      tick = 1'b1;
      model_sweep();
      step();
      tick = 1'b0;
      step();
      step();
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(2);
      cfg_inc   = ADD_WIDTH'(9);
      cfg_clr   = 1'b1;
      step();
      cfg_valid = 1'b0;
      cfg_clr   = 1'b0;
      inc_m[2]  = 9;
      acc_m[2]  = 0;
      drain(1'b0);
      start_sweep();
      drain(1'b0);

      // Asynchronous reset in the middle of a sweep (with overrun set first)
      tick = 1'b1;
      model_sweep();
      step();
      step();
      tick = 1'b0;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_ch", 32'(out_ch), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sweep_done", 32'(sweep_done), 32'd0);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      model_reset();
      @(negedge clk);
      #1;
      rst = 1'b0;
      step();
      for (int c = 0; c < NUM_CH; c++) cfg_write(c, int'($urandom_range(0, 255)), 1'b0);
      start_sweep();
      drain(1'b1);

      // Randomized config writes and sweeps under random backpressure
      repeat (25) begin
         int nw;
         nw = int'($urandom_range(0, 2));
         repeat (nw) begin
            cfg_write(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
         end
         start_sweep();
         drain(1'b1);
      end

      repeat (3) step();
      chk("final_queue", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
